prefix_addsub_seq: RTL and testbench
====================================

Name: prefix_addsub_seq

Overview:
- Sequential, limb-serial wide-integer adder/subtractor for the SIKE field-arithmetic datapath.
- Each cycle it processes one LIMB-bit slice of the operands.
- Inside a slice, carries are resolved by a parallel-prefix (Kogge-Stone) tree built from the (generate, propagate) combine operator.
- Carries ripple between slices through a registered carry.
- It also produces comparison flags (zero, a<b) for conditional-subtract steps in modular reduction.

Parameters:
- WIDTH, 512, total operand width in bits; must be a multiple of LIMB.
- LIMB, 64, bits processed per cycle; must be a power of 2, >= 2.
- NLIMB, WIDTH/LIMB, number of slices; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- mode  input  1  0 = a+b, 1 = a-b (computed as a + ~b + 1)
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; result and flags valid
- result  output  WIDTH  sum/difference modulo 2^WIDTH
- carry_out  output  1  final carry; for mode=1, 1 = no borrow (a>=b)
- zero  output  1  result == 0
- a_lt_b  output  1  mode=1 and borrow occurred; 0 in mode=0

Behaviour:

Reset:
- rst_n=0 forces the IDLE state immediately.
- busy, done, carry_out, zero and a_lt_b go to 0; result goes to 0; internal operand registers, limb index and carry go to 0.

States:
- IDLE, RUN, DONE.
- busy=1 only in RUN. done=1 only in DONE.

Start acceptance:
- In IDLE or DONE, start=1 at edge k captures a, b and mode, sets carry_reg=mode and idx=0, and moves to RUN.
- busy is high after edge k.
- start while in RUN is ignored; the operands and the in-flight operation are unaffected.

RUN state:
- At each edge, slice s = idx computes a_s + (mode ? ~b_s : b_s) + carry_reg.
- Per bit: g=a&b', p=a^b'.
- A log2(LIMB)-level prefix tree combines (g_hi,p_hi)∘(g_lo,p_lo) = (g_hi | p_hi&g_lo, p_hi&p_lo).
- Bit carries are G[i-1:0] | P[i-1:0]&carry_reg.
- Sum bits are written into result[s*LIMB +: LIMB].
- carry_reg takes the slice carry-out.
- idx increments.
- When idx==NLIMB-1, the next state is DONE.

Latency:
- Start accepted at edge k: slices complete at edges k+1..k+NLIMB.
- DONE is entered at edge k+NLIMB, so done is high for exactly one cycle after that edge.
- Total start-to-done: NLIMB cycles.

DONE state:
- Flags are registered on the DONE entry edge: carry_out = final carry, zero = (result==0), a_lt_b = mode & ~final carry.
- A start in DONE is accepted exactly as in IDLE; this allows back-to-back operations with no idle cycle.

Holding and clearing outputs:
- Without a new start, DONE goes to IDLE.
- result and the flags are held until the next accepted start.
- On an accepted start, carry_out, zero and a_lt_b clear to 0.
- result is overwritten slice by slice while busy and must not be consumed while busy=1.

Arithmetic rules:
- Wrap-around is modulo 2^WIDTH with no saturation.
- mode=1 with a==b gives result 0, carry_out 1, zero 1, a_lt_b 0.

Reset mid-operation:
- The operation is aborted, no done is produced, and all outputs return to their reset values.

No combinational path exists from any input to any output.

Test Plan:
Bench configuration: WIDTH=32, LIMB=8 (NLIMB=4).
1. Add with full carry propagation: start, mode=0, a=0xFFFFFFFF, b=0x00000001 -> done exactly 4 cycles after the start edge; result=0x00000000, carry_out=1, zero=1, a_lt_b=0; busy high for 4 cycles.
2. Subtract with borrow: mode=1, a=0x00000005, b=0x00000007 -> result=0xFFFFFFFE, carry_out=0, a_lt_b=1, zero=0. Then a=0x12345678, b=0x12345678 -> result=0, carry_out=1, zero=1, a_lt_b=0.
3. Limb-boundary carry: mode=0, a=0x00FF00FF, b=0x00010001 -> result=0x01000100, carry_out=0. Then a=0x80000000, b=0x80000000 -> result=0, carry_out=1.
4. Start while busy: start a=1, b=2 (add); raise start with a=0xAAAAAAAA at cycle 2 -> ignored; done after 4 cycles with result=0x00000003. Assert start in the DONE cycle -> accepted; the second result appears 4 cycles later.
5. Reset mid-operation: start a=0xFFFFFFFF, b=1; drop rst_n asynchronously (between edges) at cycle 2 -> busy, done, result and flags are 0 immediately; no done pulse follows. After release, a new operation completes normally.
6. Randomised: 1000 random a, b, mode at WIDTH=512, LIMB=64 -> result, carry_out, zero and a_lt_b match the reference model; done occurs at exactly 8 cycles per operation.

Source files
------------

// File: rtl/prefix_addsub_seq.sv
// prefix_addsub_seq: limb-serial wide adder/subtractor with Kogge-Stone slice carries and compare flags
module prefix_addsub_seq #(
  parameter int WIDTH = 512,
  parameter int LIMB  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             a_lt_b
);
  localparam int NLIMB = WIDTH / LIMB;
  localparam int IW    = NLIMB > 1 ? $clog2(NLIMB) : 1;
  localparam int LVL   = $clog2(LIMB);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b;
  logic r_mode, r_carry, r_nz;
  logic [IW-1:0] r_idx;
  logic w_accept, w_last, w_cout;
  logic [LIMB-1:0] w_as, w_bs, w_c, w_sum;
  logic [LVL:0][LIMB-1:0] w_g, w_p;
  assign w_accept = start && r_state != RUN;
  assign w_last   = r_idx == IW'(NLIMB - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb w_next = r_state == RUN ? (w_last ? DONE : RUN) : (start ? RUN : IDLE);
  always_comb begin
    busy = r_state == RUN;
    done = r_state == DONE;
  end
  assign w_as   = r_a[r_idx*LIMB +: LIMB];
  assign w_bs   = r_b[r_idx*LIMB +: LIMB] ^ {LIMB{r_mode}};
  assign w_g[0] = w_as & w_bs;
  assign w_p[0] = w_as ^ w_bs;
  // Each level combines every bit with the one 2^l below; the low 2^l bits pass through unchanged.
  for (genvar l = 0; l < LVL; l++) begin : g_lvl
    assign w_g[l+1] = w_g[l] | (w_p[l] & (w_g[l] << (1 << l)));
    assign w_p[l+1] = w_p[l] & ~((~w_p[l]) << (1 << l));
  end
  assign w_c    = {w_g[LVL][LIMB-2:0] | (w_p[LVL][LIMB-2:0] & {(LIMB-1){r_carry}}), r_carry};
  assign w_sum  = w_p[0] ^ w_c;
  assign w_cout = w_g[LVL][LIMB-1] | (w_p[LVL][LIMB-1] & r_carry);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_mode    <= 1'b0;
      r_carry   <= 1'b0;
      r_nz      <= 1'b0;
      r_idx     <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
      a_lt_b    <= 1'b0;
    end else if (w_accept) begin
      r_a       <= a;
      r_b       <= b;
      r_mode    <= mode;
      r_carry   <= mode;
      r_nz      <= 1'b0;
      r_idx     <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
      a_lt_b    <= 1'b0;
    end else if (r_state == RUN) begin
      result[r_idx*LIMB +: LIMB] <= w_sum;
      r_carry <= w_cout;
      r_idx   <= r_idx + 1'b1;
      r_nz    <= r_nz | (|w_sum);
      if (w_last) begin
        carry_out <= w_cout;
        zero      <= ~(r_nz | (|w_sum));
        a_lt_b    <= r_mode & ~w_cout;
      end
    end
endmodule

// File: tb/tb_prefix_addsub_seq.sv
// tb_prefix_addsub_seq: directed 32-bit scenarios plus randomized back-to-back 512-bit operations
module tb_prefix_addsub_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_start = 1'b0, s_mode = 1'b0;
  logic [31:0] s_a = '0, s_b = '0;
  logic s_busy, s_done, s_carry, s_zero, s_lt;
  logic [31:0] s_result;
  logic l_start = 1'b0, l_mode = 1'b0;
  logic [511:0] l_a = '0, l_b = '0;
  logic l_busy, l_done, l_carry, l_zero, l_lt;
  logic [511:0] l_result;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prefix_addsub_seq #(.WIDTH(32), .LIMB(8)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .mode(s_mode), .a(s_a), .b(s_b),
    .busy(s_busy), .done(s_done), .result(s_result), .carry_out(s_carry), .zero(s_zero), .a_lt_b(s_lt)
  );

  prefix_addsub_seq #(.WIDTH(512), .LIMB(64)) u_large (
    .clk(clk), .rst_n(rst_n), .start(l_start), .mode(l_mode), .a(l_a), .b(l_b),
    .busy(l_busy), .done(l_done), .result(l_result), .carry_out(l_carry), .zero(l_zero), .a_lt_b(l_lt)
  );

  function automatic void model(input logic [511:0] a, input logic [511:0] b, input logic m,
                                output logic [511:0] r, output logic c, output logic z, output logic lt);
    logic [512:0] s;
    if (m) begin
      r = a - b;
      c = a >= b;
    end else begin
      s = {1'b0, a} + {1'b0, b};
      r = s[511:0];
      c = s[512];
    end
    z  = r == '0;
    lt = m && a < b;
  endfunction

  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic m, output int lat, output int bc);
    @(negedge clk);
    s_start = 1'b1; s_a = a; s_b = b; s_mode = m;
    @(negedge clk);
    s_start = 1'b0; lat = 0; bc = 0;
    while (!s_done && lat < 20) begin
      bc += int'(s_busy);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_busy, s_done, s_result, s_carry, s_zero, s_lt} !== 37'h0) begin
      errors++; $display("FAIL reset_small got %b%b %h %b%b%b exp all zero", s_busy, s_done, s_result, s_carry, s_zero, s_lt);
    end
    checks++;
    if ({l_busy, l_done, l_result, l_carry, l_zero, l_lt} !== 517'h0) begin
      errors++; $display("FAIL reset_large got busy=%b done=%b flags=%b%b%b result=%h exp all zero", l_busy, l_done, l_carry, l_zero, l_lt, l_result);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_busy, s_done, l_busy, l_done} !== 4'b0) begin
      errors++; $display("FAIL idle_after_reset got %b exp 0000", {s_busy, s_done, l_busy, l_done});
    end
  endtask

  task automatic test_add_carry();
    int lat, bc;
    op32(32'hFFFFFFFF, 32'h1, 1'b0, lat, bc);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL add_latency got %0d exp 4", lat); end
    checks++;
    if (bc !== 4) begin errors++; $display("FAIL add_busy_cycles got %0d exp 4", bc); end
    checks++;
    if ({s_result, s_carry, s_zero, s_lt} !== {32'h0, 3'b110}) begin
      errors++; $display("FAIL add_carry got %h c%b z%b lt%b exp 00000000 c1 z1 lt0", s_result, s_carry, s_zero, s_lt);
    end
    checks++;
    if (s_busy !== 1'b0) begin errors++; $display("FAIL add_busy_in_done got %b exp 0", s_busy); end
  endtask

  task automatic test_subtract();
    int lat, bc;
    op32(32'h5, 32'h7, 1'b1, lat, bc);
    checks++;
    if ({s_result, s_carry, s_zero, s_lt} !== {32'hFFFFFFFE, 3'b001}) begin
      errors++; $display("FAIL sub_borrow got %h c%b z%b lt%b exp fffffffe c0 z0 lt1", s_result, s_carry, s_zero, s_lt);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({s_done, s_busy, s_result, s_lt} !== {2'b00, 32'hFFFFFFFE, 1'b1}) begin
      errors++; $display("FAIL sub_hold got done%b busy%b %h lt%b exp done0 busy0 fffffffe lt1", s_done, s_busy, s_result, s_lt);
    end
    op32(32'h12345678, 32'h12345678, 1'b1, lat, bc);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL sub_latency got %0d exp 4", lat); end
    checks++;
    if ({s_result, s_carry, s_zero, s_lt} !== {32'h0, 3'b110}) begin
      errors++; $display("FAIL sub_equal got %h c%b z%b lt%b exp 00000000 c1 z1 lt0", s_result, s_carry, s_zero, s_lt);
    end
  endtask

  task automatic test_limb_boundary();
    int lat, bc;
    op32(32'h00FF00FF, 32'h00010001, 1'b0, lat, bc);
    checks++;
    if ({s_result, s_carry, s_zero, s_lt} !== {32'h01000100, 3'b000}) begin
      errors++; $display("FAIL limb_carry got %h c%b z%b lt%b exp 01000100 c0 z0 lt0", s_result, s_carry, s_zero, s_lt);
    end
    op32(32'h80000000, 32'h80000000, 1'b0, lat, bc);
    checks++;
    if ({s_result, s_carry, s_zero, s_lt} !== {32'h0, 3'b110}) begin
      errors++; $display("FAIL top_carry got %h c%b z%b lt%b exp 00000000 c1 z1 lt0", s_result, s_carry, s_zero, s_lt);
    end
  endtask

  task automatic test_start_busy();
    int n;
    @(negedge clk);
    s_start = 1'b1; s_a = 32'h1; s_b = 32'h2; s_mode = 1'b0;
    @(negedge clk);
    s_start = 1'b0; n = 0;
    while (!s_done && n < 20) begin
      s_start = n == 1;
      if (n == 1) begin s_a = 32'hAAAAAAAA; s_b = 32'h55555555; s_mode = 1'b1; end
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 4) begin errors++; $display("FAIL busy_start_latency got %0d exp 4", n); end
    checks++;
    if ({s_result, s_carry, s_zero, s_lt} !== {32'h3, 3'b000}) begin
      errors++; $display("FAIL busy_start_ignored got %h c%b z%b lt%b exp 00000003 c0 z0 lt0", s_result, s_carry, s_zero, s_lt);
    end
    s_start = 1'b1; s_a = 32'h10; s_b = 32'h20; s_mode = 1'b0;
    @(negedge clk);
    s_start = 1'b0;
    checks++;
    if ({s_busy, s_done} !== 2'b10) begin errors++; $display("FAIL done_start_accept got busy%b done%b exp busy1 done0", s_busy, s_done); end
    n = 0;
    while (!s_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 4) begin errors++; $display("FAIL b2b_latency got %0d exp 4", n); end
    checks++;
    if ({s_result, s_carry, s_zero, s_lt} !== {32'h30, 3'b000}) begin
      errors++; $display("FAIL b2b_result got %h c%b z%b lt%b exp 00000030 c0 z0 lt0", s_result, s_carry, s_zero, s_lt);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    logic seen;
    op32(32'h12345678, 32'h0, 1'b0, lat, bc);
    checks++;
    if (s_result !== 32'h12345678) begin errors++; $display("FAIL pre_reset_result got %h exp 12345678", s_result); end
    @(negedge clk);
    s_start = 1'b1; s_a = 32'hFFFFFFFF; s_b = 32'h1; s_mode = 1'b0;
    @(negedge clk);
    s_start = 1'b0;
    @(negedge clk);
    checks++;
    if (s_busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", s_busy); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s_busy, s_done, s_result, s_carry, s_zero, s_lt} !== 37'h0) begin
      errors++; $display("FAIL async_reset got %b%b %h %b%b%b exp all zero", s_busy, s_done, s_result, s_carry, s_zero, s_lt);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 1) rst_n = 1'b1;
      seen |= s_done;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL aborted_done got %b exp 0", seen); end
    op32(32'h3, 32'h4, 1'b0, lat, bc);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL post_reset_latency got %0d exp 4", lat); end
    checks++;
    if ({s_result, s_carry, s_zero, s_lt} !== {32'h7, 3'b000}) begin
      errors++; $display("FAIL post_reset_result got %h c%b z%b lt%b exp 00000007 c0 z0 lt0", s_result, s_carry, s_zero, s_lt);
    end
  endtask

  task automatic test_back_to_back();
    logic [511:0] a, b, r;
    logic m, c, z, lt;
    int n;
    @(negedge clk);
    for (int k = 0; k < 1000; k++) begin
      for (int j = 0; j < 16; j++) begin
        a[j*32 +: 32] = $urandom;
        b[j*32 +: 32] = $urandom;
      end
      case ($urandom_range(0, 7))
        0: b = a;
        1: a = '1;
        2: b = '1;
        3: b = '0;
        default: ;
      endcase
      m = 1'($urandom_range(0, 1));
      model(a, b, m, r, c, z, lt);
      l_start = 1'b1; l_a = a; l_b = b; l_mode = m;
      @(negedge clk);
      l_start = 1'b0; n = 0;
      while (!l_done && n < 40) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n !== 8) begin errors++; $display("FAIL rand_latency op=%0d got %0d exp 8", k, n); end
      checks++;
      if ({l_result, l_carry, l_zero, l_lt} !== {r, c, z, lt}) begin
        errors++; $display("FAIL rand_result op=%0d m=%b got %h c%b z%b lt%b exp %h c%b z%b lt%b", k, m, l_result, l_carry, l_zero, l_lt, r, c, z, lt);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_subtract();
    test_limb_boundary();
    test_start_busy();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
